// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream entry,
// downstream head, flush request and occupancy status.
// master drives entries in and consumes the head; slave is the stage itself.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              out_nop;
    logic              flush;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready, flush,
        input  in_ready, out_valid, out_data, out_ctrl, out_nop, occupancy
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready, flush,
        output in_ready, out_valid, out_data, out_ctrl, out_nop, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer.
// Ports: clk, rst (sync, active-low), bus (pipe_stage_reg_if.slave):
//   in_valid/in_ready/in_data/in_ctrl upstream, out_valid/out_ready/
//   out_data/out_ctrl/out_nop downstream, flush, occupancy.
module pipe_stage_reg #(
    parameter int          DATA_W   = 32,
    parameter int          CTRL_W   = 8,
    parameter logic [31:0] NOP_DATA = 32'h00000013,
    parameter int          SKID     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    pipe_stage_reg_if.slave      bus
);
    localparam bit              SKID_EN = (SKID != 0);
    localparam logic [DATA_W-1:0] NOP   = DATA_W'(NOP_DATA);

    logic [DATA_W-1:0] head_d;
    logic [CTRL_W-1:0] head_c;
    logic              head_v;
    logic [DATA_W-1:0] skid_d;
    logic [CTRL_W-1:0] skid_c;
    logic              skid_v;
    logic              acc;
    logic              rel;

    // With a skid slot, ready depends only on state (skid slot free),
    // so out_ready never reaches in_ready combinationally.
    if (SKID_EN) begin : g_skid
        assign bus.in_ready = ~skid_v;
    end else begin : g_single
        assign bus.in_ready = ~head_v | bus.out_ready;
    end

    assign acc = bus.in_valid & bus.in_ready;
    assign rel = head_v & bus.out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (bus.flush) begin
            head_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (rel) begin
            if (skid_v) begin
                // Skid full means in_ready is low: no accept here.
                head_d <= skid_d;
                head_c <= skid_c;
                skid_v <= 1'b0;
            end else begin
                head_v <= acc;
                if (acc) begin
                    head_d <= bus.in_data;
                    head_c <= bus.in_ctrl;
                end
            end
        end else if (acc) begin
            if (head_v) begin
                skid_d <= bus.in_data;
                skid_c <= bus.in_ctrl;
                skid_v <= SKID_EN;
            end else begin
                head_d <= bus.in_data;
                head_c <= bus.in_ctrl;
                head_v <= 1'b1;
            end
        end
    end

    assign bus.out_valid = head_v;
    assign bus.out_nop   = ~head_v;
    assign bus.out_data  = head_v ? head_d : NOP;
    assign bus.out_ctrl  = head_v ? head_c : '0;
    assign bus.occupancy = {1'b0, head_v} + {1'b0, skid_v};
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a SKID=1 and a SKID=0 stage share one stimulus
// stream and are compared every cycle against an entry-list model.
module tb_pipe_stage_reg;
    typedef logic [39:0] ent_t;
    typedef struct packed {
        logic [1:0]       n;
        ent_t [1:0]       e;
    } mq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        iv = 1'b0;
    logic        ordy = 1'b0;
    logic        fl = 1'b0;
    logic [31:0] id = '0;
    logic [7:0]  ic = '0;
    bit          live = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    mq_t         m1 = '0;
    mq_t         m0 = '0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) b1 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) b0 ();

    assign b1.in_valid  = iv;
    assign b1.in_data   = id;
    assign b1.in_ctrl   = ic;
    assign b1.out_ready = ordy;
    assign b1.flush     = fl;
    assign b0.in_valid  = iv;
    assign b0.in_data   = id;
    assign b0.in_ctrl   = ic;
    assign b0.out_ready = ordy;
    assign b0.flush     = fl;

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .NOP_DATA(32'h00000013), .SKID(1)
    ) u1 (
        .clk(clk), .rst(rst), .bus(b1)
    );

    pipe_stage_reg #(
        .DATA_W(32), .CTRL_W(8), .NOP_DATA(32'h00000013), .SKID(0)
    ) u0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    // Capacity rule: skid stage holds two, single stage may accept
    // while full only if its head leaves on the same edge.
    function automatic bit mrdy(mq_t m, bit skid, logic r);
        return skid ? (m.n < 2) : (m.n == 0 || r == 1'b1);
    endfunction

    function automatic mq_t mstep(mq_t m, bit skid, logic r, logic f,
                                  logic v, logic o, ent_t din);
        mq_t nm;
        bit  rel;
        bit  acc;
        nm = m;
        if (r !== 1'b1 || f === 1'b1) begin
            nm.n = 0;
        end else begin
            rel = (m.n > 0) && (o == 1'b1);
            acc = (v == 1'b1) && mrdy(m, skid, o);
            if (rel) begin
                nm.e[0] = nm.e[1];
                nm.n = nm.n - 2'd1;
            end
            if (acc) begin
                nm.e[nm.n[0]] = din;
                nm.n = nm.n + 2'd1;
            end
        end
        return nm;
    endfunction

    always @(posedge clk) begin
        m1 <= mstep(m1, 1'b1, rst, fl, iv, ordy, {ic, id});
        m0 <= mstep(m0, 1'b0, rst, fl, iv, ordy, {ic, id});
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic unit_chk(input string tag, input bit skid, input mq_t m,
                            input logic vld, input logic rdy,
                            input logic nop, input logic [31:0] d,
                            input logic [7:0] c, input logic [1:0] occ);
        bit          ev;
        logic [31:0] ed;
        logic [7:0]  ec;
        ev = (m.n > 0);
        ed = ev ? m.e[0][31:0] : 32'h00000013;
        ec = ev ? m.e[0][39:32] : 8'h00;
        chk({tag, ".out_valid"}, 64'(vld), 64'(ev));
        chk({tag, ".out_nop"}, 64'(nop), 64'(!ev));
        chk({tag, ".out_data"}, 64'(d), 64'(ed));
        chk({tag, ".out_ctrl"}, 64'(c), 64'(ec));
        chk({tag, ".occupancy"}, 64'(occ), 64'(m.n));
        chk({tag, ".in_ready"}, 64'(rdy), 64'(mrdy(m, skid, ordy)));
    endtask

    always @(negedge clk) begin
        if (live) begin
            unit_chk("u1", 1'b1, m1, b1.out_valid, b1.in_ready, b1.out_nop,
                     b1.out_data, b1.out_ctrl, b1.occupancy);
            unit_chk("u0", 1'b0, m0, b0.out_valid, b0.in_ready, b0.out_nop,
                     b0.out_data, b0.out_ctrl, b0.occupancy);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic o, input logic f);
        iv   = v;
        id   = d;
        ic   = d[7:0] ^ 8'h5A;
        ordy = o;
        fl   = f;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        live = 1'b1;
        step();
        step();
        chk("rst_valid", 64'(b1.out_valid), 64'd0);
        chk("rst_data", 64'(b1.out_data), 64'h13);
        chk("rst_occ", 64'(b1.occupancy), 64'd0);
        chk("rst_ready", 64'(b1.in_ready), 64'd1);

        // Streaming 1,2,3 with out_ready high
        rst = 1'b1;
        drive(1'b1, 32'd1, 1'b1, 1'b0);
        step();
        chk("stream_1", 64'(b1.out_data), 64'd1);
        chk("stream_ctrl1", 64'(b1.out_ctrl), 64'h5B);
        drive(1'b1, 32'd2, 1'b1, 1'b0);
        step();
        chk("stream_2", 64'(b1.out_data), 64'd2);
        drive(1'b1, 32'd3, 1'b1, 1'b0);
        step();
        chk("stream_3", 64'(b1.out_data), 64'd3);
        chk("stream_occ", 64'(b1.occupancy), 64'd1);
        drive(1'b0, 32'd0, 1'b1, 1'b0);
        step();
        chk("drain_nop", 64'(b1.out_nop), 64'd1);

        // Backpressure A,B,C
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step();
        chk("bp_occ2", 64'(b1.occupancy), 64'd2);
        chk("bp_model_occ2", 64'(m1.n), 64'd2);
        chk("bp_notready", 64'(b1.in_ready), 64'd0);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        step();
        chk("bp_hold_A", 64'(b1.out_data), 64'hA);
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        step();
        chk("bp_out_B", 64'(b1.out_data), 64'hB);
        step();
        chk("bp_out_C", 64'(b1.out_data), 64'hC);
        chk("bp_model_C", 64'(m1.e[0][31:0]), 64'hC);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        chk("bp_empty", 64'(b1.occupancy), 64'd0);

        // Flush with two held and an incoming entry
        drive(1'b1, 32'hD, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hE, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hF, 1'b0, 1'b1);
        step();
        chk("fl_valid", 64'(b1.out_valid), 64'd0);
        chk("fl_data", 64'(b1.out_data), 64'h13);
        chk("fl_ctrl", 64'(b1.out_ctrl), 64'd0);
        chk("fl_occ", 64'(b1.occupancy), 64'd0);
        chk("fl_model_occ", 64'(m1.n), 64'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Single-entry pass-through
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h51, 1'b1, 1'b0);
        #1;
        chk("s0_ready", 64'(b0.in_ready), 64'd1);
        step();
        chk("s0_replace", 64'(b0.out_data), 64'h51);
        chk("s0_occ", 64'(b0.occupancy), 64'd1);

        // Reset mid-stream
        drive(1'b1, 32'h60, 1'b0, 1'b0);
        step();
        chk("mid_occ2", 64'(b1.occupancy), 64'd2);
        rst = 1'b0;
        drive(1'b1, 32'h61, 1'b1, 1'b0);
        step();
        chk("mid_rst_occ", 64'(b1.occupancy), 64'd0);
        chk("mid_rst_data", 64'(b1.out_data), 64'h13);
        rst = 1'b1;
        drive(1'b1, 32'h70, 1'b1, 1'b0);
        #1;
        chk("mid_ready", 64'(b1.in_ready), 64'd1);
        step();
        chk("mid_first", 64'(b1.out_data), 64'h70);

        // Mixed valid/ready/flush pattern
        for (int i = 0; i < 48; i++) begin
            drive(((i % 3) != 0), 32'h100 + 32'(i), ((i % 7) != 3 &&
                  (i % 5) != 1), (i == 29));
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        step();
        chk("end_empty", 64'(b1.occupancy), 64'd0);

        @(negedge clk);
        live = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
